// File: rtl/chroni_line_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : chroni_line_scheduler
//  Purpose  : sys_clk-domain sequencer for the VGA double line buffer. Issues
//             one render request per source line, alternating buffer halves
//             (0 / 640), paces requests from scanline_start and flags lines
//             that could not be rendered in time (overrun).
//  Options  : `define CHRONI_LINE_IRQ_EN adds irq_line / line_irq (one-cycle
//             pulse at the schedule point where the displayed line matches).
//  Revision : 1.0 - initial release
// ============================================================================
module chroni_line_scheduler #(
  parameter int LINES     = 240,
  parameter int LINE_BITS = 9
) (
  input  logic                 sys_clk,
  input  logic                 reset_n,
  input  logic                 frame_start,
  input  logic                 render_start,
  input  logic                 scanline_start,
  input  logic                 mode_changed,
  input  logic                 pixel_scale,
  input  logic                 render_done,
`ifdef CHRONI_LINE_IRQ_EN
  input  logic [LINE_BITS-1:0] irq_line,
  output logic                 line_irq,
`endif
  output logic                 render_req,
  output logic [LINE_BITS-1:0] render_line,
  output logic                 render_buf,
  output logic                 frame_active,
  output logic                 overrun,
  output logic [7:0]           overrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [LINE_BITS-1:0] c_LAST_LINE = LINE_BITS'(LINES - 1);
  localparam logic [LINE_BITS-1:0] c_ONE       = LINE_BITS'(1);

  state_t               r_state;
  logic                 r_k4;          // latched pixel_scale: 4 VGA lines per half
  logic [2:0]           r_sl_cnt;
  logic [LINE_BITS-1:0] r_next_line;
  logic [LINE_BITS-1:0] r_pend_line;
  logic                 r_pending;
  logic                 r_abort;
  logic                 r_req;
  logic [LINE_BITS-1:0] r_line;
  logic                 r_buf;
  logic                 r_frame_active;
  logic                 r_overrun;
  logic [7:0]           r_overrun_cnt;
`ifdef CHRONI_LINE_IRQ_EN
  logic                 r_line_irq;
`endif

  logic                 w_done;
  logic                 w_sched;
  logic [2:0]           w_reload;
  logic [7:0]           w_cnt_inc;

  // done only counts while a request is actually outstanding
  assign w_done    = render_done & r_req;
  // schedule point: scanline decrement 1 -> 0 while lines remain to be issued
  assign w_sched   = (r_state == S_RUN) && !r_abort && !frame_start && scanline_start &&
                     (r_sl_cnt == 3'd1) && (r_next_line <= c_LAST_LINE);
  assign w_reload  = r_k4 ? 3'd4 : 3'd2;
  assign w_cnt_inc = (r_overrun_cnt == 8'hFF) ? 8'hFF : r_overrun_cnt + 8'd1;

  // Scheduler FSM: state, request handshake, scanline pacing and overrun tracking
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_k4           <= 1'b0;
      r_sl_cnt       <= 3'd0;
      r_next_line    <= '0;
      r_pend_line    <= '0;
      r_pending      <= 1'b0;
      r_abort        <= 1'b0;
      r_req          <= 1'b0;
      r_line         <= '0;
      r_buf          <= 1'b0;
      r_frame_active <= 1'b0;
      r_overrun      <= 1'b0;
      r_overrun_cnt  <= 8'd0;
`ifdef CHRONI_LINE_IRQ_EN
      r_line_irq     <= 1'b0;
`endif
    end else begin
      r_overrun <= 1'b0;
`ifdef CHRONI_LINE_IRQ_EN
      r_line_irq <= 1'b0;
`endif
      if (frame_start) r_overrun_cnt <= 8'd0;

      if (mode_changed) begin
        // timing reprogrammed: abandon the frame, later dones find r_req low
        r_state        <= S_IDLE;
        r_req          <= 1'b0;
        r_pending      <= 1'b0;
        r_abort        <= 1'b0;
        r_sl_cnt       <= 3'd0;
        r_frame_active <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (render_start) begin
              r_k4           <= pixel_scale;
              r_sl_cnt       <= 3'd2;
              r_req          <= 1'b1;
              r_line         <= '0;
              r_buf          <= 1'b0;
              r_frame_active <= 1'b1;
              r_next_line    <= '0;
              r_pending      <= 1'b0;
              r_abort        <= 1'b0;
              r_state        <= S_PRIME;
            end
          end

          S_PRIME, S_RUN, S_DRAIN: begin
            if (w_done) r_req <= 1'b0;

            if (r_abort || frame_start) begin
              // new frame began mid-render: wait only for the outstanding done
              r_abort <= 1'b1;
              if (!r_req || w_done) begin
                r_state        <= S_IDLE;
                r_abort        <= 1'b0;
                r_pending      <= 1'b0;
                r_sl_cnt       <= 3'd0;
                r_frame_active <= 1'b0;
              end
            end else if (r_state == S_PRIME) begin
              if (w_done) begin
                r_state     <= S_RUN;
                r_next_line <= c_ONE;
              end
            end else if (r_state == S_RUN) begin
              if (scanline_start) begin
                if (r_sl_cnt == 3'd1)      r_sl_cnt <= w_reload;
                else if (r_sl_cnt != 3'd0) r_sl_cnt <= r_sl_cnt - 3'd1;
              end

              if (w_sched) begin
                r_next_line <= r_next_line + c_ONE;
`ifdef CHRONI_LINE_IRQ_EN
                if ((r_next_line - c_ONE) == irq_line) r_line_irq <= 1'b1;
`endif
                if (r_req) begin
                  // request still up (or finishing now): park this line as pending;
                  // a coincident done is not an overrun unless a pending line is lost
                  r_pending   <= 1'b1;
                  r_pend_line <= r_next_line;
                  if (!w_done || r_pending) begin
                    r_overrun     <= 1'b1;
                    r_overrun_cnt <= w_cnt_inc;
                  end
                end else begin
                  r_req     <= 1'b1;
                  r_line    <= r_next_line;
                  r_buf     <= r_next_line[0];
                  r_pending <= 1'b0;
                  if (r_pending) begin
                    r_overrun     <= 1'b1;
                    r_overrun_cnt <= w_cnt_inc;
                  end
                  if (r_next_line == c_LAST_LINE) r_state <= S_DRAIN;
                end
              end else if (!r_req && r_pending) begin
                // pending line goes out after the mandatory low cycle
                r_req     <= 1'b1;
                r_line    <= r_pend_line;
                r_buf     <= r_pend_line[0];
                r_pending <= 1'b0;
                if (r_pend_line == c_LAST_LINE) r_state <= S_DRAIN;
              end
            end else begin
              if (w_done) begin
                r_state        <= S_DONE;
                r_frame_active <= 1'b0;
              end
            end
          end

          S_DONE: begin
            if (frame_start) r_state <= S_IDLE;
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign render_req   = r_req;
  assign render_line  = r_line;
  assign render_buf   = r_buf;
  assign frame_active = r_frame_active;
  assign overrun      = r_overrun;
  assign overrun_cnt  = r_overrun_cnt;
`ifdef CHRONI_LINE_IRQ_EN
  assign line_irq     = r_line_irq;
`endif

endmodule
`default_nettype wire
